fpu_align_add: RTL and testbench

//  Multi-cycle significand alignment and add/subtract stage; sits directly upstream of fpu_normalizer.

---
 rtl/fpu_align_add_pkg.sv | 21 ++
 rtl/fpu_operand_order.sv | 42 ++++
 rtl/fpu_align_add.sv | 169 ++++++++++++++++
 tb/tb_fpu_align_add.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_align_add_pkg.sv
// ============================================================================
// fpu_align_add_pkg : shared FSM encoding and default field widths
// Rev 1.0
// ============================================================================
`default_nettype none

package fpu_align_add_pkg;

  localparam int C_MANTISSA_SIZE_DEF = 23;
  localparam int C_EXPONENT_SIZE_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_ADD   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fpu_operand_order.sv
// ============================================================================
// fpu_operand_order : orders two operands into BIG/SMALL by magnitude and
//                     returns the unsigned exponent difference
// Rev 1.0
// ============================================================================
`default_nettype none

module fpu_operand_order
  import fpu_align_add_pkg::*;
#(
  parameter int Mantissa_Size = C_MANTISSA_SIZE_DEF,
  parameter int Exponent_Size = C_EXPONENT_SIZE_DEF
) (
  input  logic                     a_sign_i,
  input  logic [Exponent_Size-1:0] a_exp_i,
  input  logic [Mantissa_Size-1:0] a_sig_i,
  input  logic                     b_sign_i,
  input  logic [Exponent_Size-1:0] b_exp_i,
  input  logic [Mantissa_Size-1:0] b_sig_i,
  output logic                     big_sign_o,
  output logic [Exponent_Size-1:0] big_exp_o,
  output logic [Mantissa_Size-1:0] big_sig_o,
  output logic                     small_sign_o,
  output logic [Mantissa_Size-1:0] small_sig_o,
  output logic [Exponent_Size-1:0] diff_o
);

  logic w_a_big;

  // A wins exponent ties on equal significands, so x-x always leaves A as BIG
  assign w_a_big = (a_exp_i > b_exp_i) || ((a_exp_i == b_exp_i) && (a_sig_i >= b_sig_i));

  assign big_sign_o   = w_a_big ? a_sign_i : b_sign_i;
  assign big_exp_o    = w_a_big ? a_exp_i  : b_exp_i;
  assign big_sig_o    = w_a_big ? a_sig_i  : b_sig_i;
  assign small_sign_o = w_a_big ? b_sign_i : a_sign_i;
  assign small_sig_o  = w_a_big ? b_sig_i  : a_sig_i;
  assign diff_o       = w_a_big ? (a_exp_i - b_exp_i) : (b_exp_i - a_exp_i);

endmodule

`default_nettype wire

// File: rtl/fpu_align_add.sv
// ============================================================================
// fpu_align_add : multi-cycle significand alignment (one bit per cycle) and
//                 magnitude add/subtract feeding fpu_normalizer
// Rev 1.0
// ============================================================================
`default_nettype none

module fpu_align_add
  import fpu_align_add_pkg::*;
#(
  parameter int Mantissa_Size = C_MANTISSA_SIZE_DEF,
  parameter int Exponent_Size = C_EXPONENT_SIZE_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     a_sign,
  input  logic [Exponent_Size-1:0] a_exponent,
  input  logic [Mantissa_Size-1:0] a_significand,
  input  logic                     b_sign,
  input  logic [Exponent_Size-1:0] b_exponent,
  input  logic [Mantissa_Size-1:0] b_significand,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sign,
  output logic [Exponent_Size-1:0] out_exponent,
  output logic [Mantissa_Size:0]   out_mantissa,
  output logic                     out_zero
);

  logic                     w_big_sign, w_small_sign;
  logic [Exponent_Size-1:0] w_big_exp, w_diff;
  logic [Mantissa_Size-1:0] w_big_sig, w_small_sig;
  logic [Mantissa_Size:0]   w_result;

  fpu_operand_order #(
    .Mantissa_Size (Mantissa_Size),
    .Exponent_Size (Exponent_Size)
  ) u_order (
    .a_sign_i     (a_sign),
    .a_exp_i      (a_exponent),
    .a_sig_i      (a_significand),
    .b_sign_i     (b_sign),
    .b_exp_i      (b_exponent),
    .b_sig_i      (b_significand),
    .big_sign_o   (w_big_sign),
    .big_exp_o    (w_big_exp),
    .big_sig_o    (w_big_sig),
    .small_sign_o (w_small_sign),
    .small_sig_o  (w_small_sig),
    .diff_o       (w_diff)
  );

  state_e                   state_q, state_d;
  logic                     big_sign_q, big_sign_d;
  logic [Exponent_Size-1:0] big_exp_q, big_exp_d;
  logic [Mantissa_Size-1:0] big_sig_q, big_sig_d;
  logic [Mantissa_Size-1:0] small_sig_q, small_sig_d;
  logic                     sub_q, sub_d;
  logic [Exponent_Size-1:0] cnt_q, cnt_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_sign_q, out_sign_d;
  logic [Exponent_Size-1:0] out_exp_q, out_exp_d;
  logic [Mantissa_Size:0]   out_mant_q, out_mant_d;
  logic                     out_zero_q, out_zero_d;

  // Ordering guarantees BIG >= SMALL after alignment, so the subtraction never borrows
  assign w_result = sub_q ? {1'b0, big_sig_q - small_sig_q}
                          : ({1'b0, big_sig_q} + {1'b0, small_sig_q});

  always_comb begin
    state_d     = state_q;
    big_sign_d  = big_sign_q;
    big_exp_d   = big_exp_q;
    big_sig_d   = big_sig_q;
    small_sig_d = small_sig_q;
    sub_d       = sub_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_sign_d  = out_sign_q;
    out_exp_d   = out_exp_q;
    out_mant_d  = out_mant_q;
    out_zero_d  = out_zero_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          big_sign_d  = w_big_sign;
          big_exp_d   = w_big_exp;
          big_sig_d   = w_big_sig;
          small_sig_d = w_small_sig;
          sub_d       = w_big_sign ^ w_small_sign;
          if (w_diff == '0) begin
            state_d = ST_ADD;
          end else if (32'(w_diff) > 32'(Mantissa_Size)) begin
            small_sig_d = '0;
            state_d     = ST_ADD;
          end else begin
            cnt_d   = w_diff;
            state_d = ST_ALIGN;
          end
        end
      end
      ST_ALIGN: begin
        small_sig_d = small_sig_q >> 1;
        cnt_d       = cnt_q - Exponent_Size'(1);
        if (cnt_q == Exponent_Size'(1)) begin
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        out_mant_d  = w_result;
        out_zero_d  = (w_result == '0);
        out_sign_d  = (w_result == '0) ? 1'b0 : big_sign_q;
        out_exp_d   = big_exp_q;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      big_sign_q  <= 1'b0;
      big_exp_q   <= '0;
      big_sig_q   <= '0;
      small_sig_q <= '0;
      sub_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_mant_q  <= '0;
      out_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      big_sign_q  <= big_sign_d;
      big_exp_q   <= big_exp_d;
      big_sig_q   <= big_sig_d;
      small_sig_q <= small_sig_d;
      sub_q       <= sub_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sign_q  <= out_sign_d;
      out_exp_q   <= out_exp_d;
      out_mant_q  <= out_mant_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign in_ready     = (state_q == ST_IDLE);
  assign out_valid    = out_valid_q;
  assign out_sign     = out_sign_q;
  assign out_exponent = out_exp_q;
  assign out_mantissa = out_mant_q;
  assign out_zero     = out_zero_q;

endmodule

`default_nettype wire

// File: tb/tb_fpu_align_add.sv
// ============================================================================
// tb_fpu_align_add : scoreboard bench for the align/add stage (M=23, E=8)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fpu_align_add;

  localparam int M = 23;
  localparam int E = 8;

  typedef struct packed {
    logic         sign;
    logic [E-1:0] exp;
    logic [M:0]   mant;
    logic         zero;
    int           lat;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         a_sign = 1'b0, b_sign = 1'b0;
  logic [E-1:0] a_exponent = '0, b_exponent = '0;
  logic [M-1:0] a_significand = '0, b_significand = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_sign;
  logic [E-1:0] out_exponent;
  logic [M:0]   out_mantissa;
  logic         out_zero;

  int   n_cmp = 0;
  int   n_err = 0;
  res_t sb[$];

  fpu_align_add #(.Mantissa_Size(M), .Exponent_Size(E)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .a_sign        (a_sign),
    .a_exponent    (a_exponent),
    .a_significand (a_significand),
    .b_sign        (b_sign),
    .b_exponent    (b_exponent),
    .b_significand (b_significand),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sign      (out_sign),
    .out_exponent  (out_exponent),
    .out_mantissa  (out_mantissa),
    .out_zero      (out_zero)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic as, input logic [E-1:0] ae, input logic [M-1:0] asg,
                                 input logic bs, input logic [E-1:0] be, input logic [M-1:0] bsg);
    res_t r;
    logic a_big;
    logic bsn, ssn;
    logic [E-1:0] bex, sex;
    logic [M-1:0] bsig, ssig;
    int d;
    a_big = (ae > be) || (ae == be && asg >= bsg);
    bsn = a_big ? as : bs;   ssn = a_big ? bs : as;
    bex = a_big ? ae : be;   sex = a_big ? be : ae;
    bsig = a_big ? asg : bsg; ssig = a_big ? bsg : asg;
    d = int'(bex) - int'(sex);
    if (d > M) begin
      ssig = '0;
      r.lat = 2;
    end else begin
      ssig = ssig >> d;
      r.lat = d + 2;
    end
    if (bsn == ssn) r.mant = {1'b0, bsig} + {1'b0, ssig};
    else            r.mant = {1'b0, bsig - ssig};
    r.zero = (r.mant == '0);
    r.sign = r.zero ? 1'b0 : bsn;
    r.exp  = bex;
    return r;
  endfunction

  // Presents one operand pair and waits for out_valid; lat counts the accepting edge as 1.
  task automatic drive_op(input logic as, input logic [E-1:0] ae, input logic [M-1:0] asg,
                          input logic bs, input logic [E-1:0] be, input logic [M-1:0] bsg,
                          output res_t obs);
    int n;
    a_sign = as; a_exponent = ae; a_significand = asg;
    b_sign = bs; b_exponent = be; b_significand = bsg;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (out_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    obs.sign = out_sign;
    obs.exp  = out_exponent;
    obs.mant = out_mantissa;
    obs.zero = out_zero;
    obs.lat  = n;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if ({out_sign, out_exponent, out_mantissa, out_zero} !== '0) begin
      n_err++; $display("FAIL reset_outputs got %b/%h/%h/%b want all zero", out_sign, out_exponent, out_mantissa, out_zero);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic         as_t[9], bs_t[9];
    logic [E-1:0] ae_t[9], be_t[9];
    logic [M-1:0] asg_t[9], bsg_t[9];
    res_t obs, exp_r;
    as_t = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
    ae_t = '{127, 128, 130, 250, 100, 140, 140, 140, 90};
    asg_t = '{23'h400000, 23'h600000, 23'h5A0000, 23'h4ABCDE, 23'h400000, 23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF, 23'h400001};
    bs_t = '{0, 0, 1, 0, 1, 1, 0, 0, 0};
    be_t = '{127, 127, 130, 50, 100, 118, 117, 116, 90};
    bsg_t = '{23'h400000, 23'h400000, 23'h5A0000, 23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF, 23'h400000};
    // Spec-derived anchors for the first four cases
    sb.push_back('{1'b0, 8'd127, 24'h800000, 1'b0, 2});
    sb.push_back('{1'b0, 8'd128, 24'h800000, 1'b0, 3});
    sb.push_back('{1'b0, 8'd130, 24'h000000, 1'b1, 2});
    sb.push_back('{1'b0, 8'd250, 24'h4ABCDE, 1'b0, 2});
    for (int i = 4; i < 9; i++) sb.push_back(model(as_t[i], ae_t[i], asg_t[i], bs_t[i], be_t[i], bsg_t[i]));
    for (int i = 0; i < 9; i++) begin
      drive_op(as_t[i], ae_t[i], asg_t[i], bs_t[i], be_t[i], bsg_t[i], obs);
      exp_r = sb.pop_front();
      n_cmp++; if (obs.mant !== exp_r.mant) begin n_err++; $display("FAIL dir%0d_mant got %h want %h", i, obs.mant, exp_r.mant); end
      n_cmp++; if (obs.exp !== exp_r.exp) begin n_err++; $display("FAIL dir%0d_exp got %0d want %0d", i, obs.exp, exp_r.exp); end
      n_cmp++; if ({obs.sign, obs.zero} !== {exp_r.sign, exp_r.zero}) begin
        n_err++; $display("FAIL dir%0d_sign_zero got %b%b want %b%b", i, obs.sign, obs.zero, exp_r.sign, exp_r.zero);
      end
      n_cmp++; if (obs.lat !== exp_r.lat) begin n_err++; $display("FAIL dir%0d_latency got %0d want %0d", i, obs.lat, exp_r.lat); end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    res_t obs, exp_r;
    logic [E+M+2:0] snap;
    sb.push_back(model(1'b0, 8'd129, 23'h700000, 1'b1, 8'd126, 23'h600000));
    drive_op(1'b0, 8'd129, 23'h700000, 1'b1, 8'd126, 23'h600000, obs);
    exp_r = sb.pop_front();
    n_cmp++; if (obs.mant !== exp_r.mant) begin n_err++; $display("FAIL bp_mant got %h want %h", obs.mant, exp_r.mant); end
    snap = {out_sign, out_exponent, out_mantissa, out_zero};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if ({out_valid, in_ready} !== 2'b10) begin
        n_err++; $display("FAIL bp_hold%0d_valid_ready got %b%b want 10", i, out_valid, in_ready);
      end
      n_cmp++; if ({out_sign, out_exponent, out_mantissa, out_zero} !== snap) begin
        n_err++; $display("FAIL bp_hold%0d_stable got %h want %h", i, {out_sign, out_exponent, out_mantissa, out_zero}, snap);
      end
    end
    release_out();
    n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL bp_release got valid/ready %b%b want 01", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    a_sign = 1'b0; a_exponent = 8'd150; a_significand = 23'h400000;
    b_sign = 1'b0; b_exponent = 8'd130; b_significand = 23'h7FFFFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL midreset_state got valid/ready %b%b want 01", out_valid, in_ready);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midreset_no_result got out_valid seen=%b want 0", seen); end
  endtask

  task automatic test_back_to_back();
    res_t obs, exp_r;
    logic as, bs;
    logic [E-1:0] ae, be;
    logic [M-1:0] asg, bsg;
    for (int i = 0; i < 20; i++) begin
      as  = 1'($urandom_range(0, 1));
      bs  = 1'($urandom_range(0, 1));
      ae  = 8'($urandom_range(40, 200));
      be  = 8'(int'(ae) + $urandom_range(0, 60) - 30);
      asg = 23'($urandom_range(0, 23'h3FFFFF)) | 23'h400000;
      bsg = 23'($urandom_range(0, 23'h3FFFFF)) | 23'h400000;
      if (i == 0) begin be = ae; bsg = asg; bs = ~as; end
      sb.push_back(model(as, ae, asg, bs, be, bsg));
      drive_op(as, ae, asg, bs, be, bsg, obs);
      exp_r = sb.pop_front();
      n_cmp++; if (obs !== exp_r) begin
        n_err++; $display("FAIL b2b%0d got %b/%0d/%h/%b lat%0d want %b/%0d/%h/%b lat%0d", i,
                          obs.sign, obs.exp, obs.mant, obs.zero, obs.lat, exp_r.sign, exp_r.exp, exp_r.mant, exp_r.zero, exp_r.lat);
      end
      release_out();
      n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin
        n_err++; $display("FAIL b2b%0d_handshake got valid/ready %b%b want 01", i, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
